// File: rtl/mul_definition_pkg.sv
// Shared multiply/accumulate definitions: function codes and the decoded accumulator op.
// The decode helper lives here so every consumer agrees on what a Func value means.
package mul_definition;

    localparam logic [5:0] FUNC_MADD  = 6'h00;
    localparam logic [5:0] FUNC_MADDU = 6'h01;
    localparam logic [5:0] FUNC_MSUB  = 6'h04;
    localparam logic [5:0] FUNC_MSUBU = 6'h05;
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MFHI  = 4'd1,
        OP_MFLO  = 4'd2,
        OP_MTHI  = 4'd3,
        OP_MTLO  = 4'd4,
        OP_MULT  = 4'd5,
        OP_MULTU = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } acc_op_e;

    // Product ops need the multiplier path selected and MTHI/MTLO need the register path;
    // an inconsistent source select is treated as an unknown op rather than guessed at.
    function automatic acc_op_e decode_op(input logic en, input logic mulop,
                                          input logic selb, input logic [5:0] func);
        acc_op_e op;
        op = OP_NONE;
        if (!en) begin
            op = OP_NONE;
        end else if (mulop) begin
            if (selb) begin
                case (func)
                    FUNC_MADD:  op = OP_MADD;
                    FUNC_MADDU: op = OP_MADDU;
                    FUNC_MSUB:  op = OP_MSUB;
                    FUNC_MSUBU: op = OP_MSUBU;
                    default:    op = OP_NONE;
                endcase
            end else begin
                op = OP_NONE;
            end
        end else begin
            case (func)
                FUNC_MFHI:  op = OP_MFHI;
                FUNC_MFLO:  op = OP_MFLO;
                FUNC_MTHI:  op = selb ? OP_NONE : OP_MTHI;
                FUNC_MTLO:  op = selb ? OP_NONE : OP_MTLO;
                FUNC_MULT:  op = selb ? OP_MULT : OP_NONE;
                FUNC_MULTU: op = selb ? OP_MULTU : OP_NONE;
                default:    op = OP_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/acc_addsub64.sv
// Combinational 64-bit add/subtract. carry is the add carry-out, or the borrow-out when
// subtracting; ovf is two's-complement overflow of the same operation.
module acc_addsub64
    import mul_definition::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        sub,
    output logic [63:0] sum,
    output logic        carry,
    output logic        ovf
);

    logic [64:0] wide_s;

    // A 65-bit difference leaves the borrow in its top bit, so one adder serves both ops.
    always_comb begin
        wide_s = 65'd0;
        ovf    = 1'b0;
        if (sub) begin
            wide_s = {1'b0, a} - {1'b0, b};
            ovf    = (a[63] != b[63]) && (wide_s[63] != a[63]);
        end else begin
            wide_s = {1'b0, a} + {1'b0, b};
            ovf    = (a[63] == b[63]) && (wide_s[63] != a[63]);
        end
    end

    assign sum   = wide_s[63:0];
    assign carry = wide_s[64];

endmodule

// File: rtl/acc_unit.sv
// HI/LO accumulator for the multiply unit. The result word and flags are combinational
// in the issuing cycle; HI and LO update on the following edge only when committed.
module acc_unit
    import mul_definition::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        En,
    input  logic        MULSelB,
    input  logic        MULOp,
    input  logic [5:0]  Func,
    input  logic [31:0] A,
    input  logic [63:0] MULout,
    input  logic        Stall,
    input  logic        Flush,
    output logic [31:0] ACCout,
    output logic        ACCO,
    output logic        ACCZ,
    output logic        ACCN,
    output logic        ACCC
);

    acc_op_e     op_s;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] hi_next_s;
    logic [31:0] lo_next_s;
    logic [63:0] sum_s;
    logic        sub_s;
    logic        carry_s;
    logic        ovf_s;
    logic        commit_s;
    logic        valid_s;
    logic [31:0] out_s;
    logic        o_s;
    logic        c_s;

    assign op_s     = decode_op(En, MULOp, MULSelB, Func);
    assign sub_s    = (op_s == OP_MSUB) || (op_s == OP_MSUBU);
    assign commit_s = En & ~Stall & ~Flush;

    acc_addsub64 u_addsub (
        .a     ({hi_r, lo_r}),
        .b     (MULout),
        .sub   (sub_s),
        .sum   (sum_s),
        .carry (carry_s),
        .ovf   (ovf_s)
    );

    // Next HI/LO per op; non-writing ops hold the current value.
    always_comb begin
        hi_next_s = hi_r;
        lo_next_s = lo_r;
        case (op_s)
            OP_MULT, OP_MULTU: begin
                hi_next_s = MULout[63:32];
                lo_next_s = MULout[31:0];
            end
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                hi_next_s = sum_s[63:32];
                lo_next_s = sum_s[31:0];
            end
            OP_MTHI: hi_next_s = A;
            OP_MTLO: lo_next_s = A;
            default: begin
                hi_next_s = hi_r;
                lo_next_s = lo_r;
            end
        endcase
    end

    // Result word plus overflow/carry; the signed/unsigned variants differ only in ACCO.
    always_comb begin
        out_s   = 32'd0;
        o_s     = 1'b0;
        c_s     = 1'b0;
        valid_s = 1'b1;
        case (op_s)
            OP_MFHI:  out_s = hi_r;
            OP_MFLO:  out_s = lo_r;
            OP_MTHI, OP_MTLO: out_s = A;
            OP_MULT: begin
                out_s = MULout[31:0];
                o_s   = (MULout[63:32] != {32{MULout[31]}});
            end
            OP_MULTU: begin
                out_s = MULout[31:0];
                o_s   = (MULout[63:32] != 32'd0);
            end
            OP_MADD, OP_MSUB: begin
                out_s = sum_s[31:0];
                o_s   = ovf_s;
                c_s   = carry_s;
            end
            OP_MADDU, OP_MSUBU: begin
                out_s = sum_s[31:0];
                c_s   = carry_s;
            end
            default: valid_s = 1'b0;
        endcase
    end

    assign ACCout = out_s;
    assign ACCO   = o_s;
    assign ACCC   = c_s;
    assign ACCZ   = valid_s & (out_s == 32'd0);
    assign ACCN   = out_s[31];

    // HI/LO state: cleared asynchronously, written only on a committed edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (commit_s) begin
            hi_r <= hi_next_s;
            lo_r <= lo_next_s;
        end
    end

endmodule
